onchip_mem_arbiter: RTL and testbench

Shares the single-port 1024x32 on-chip RAM (byte-enabled, 1-cycle read latency, unregistered q) between two Avalon-MM requesters: the Nios data master (port 0) and the SPI transfer engine (port 1).
- Arbitrates per cycle with round-robin fairness.
- Drives the RAM's address, byteenable, chipselect, write, writedata and clken.
- Returns registered read data to the correct requester with a readdatavalid strobe.

---
 rtl/onchip_mem_pkg.sv | 14 +
 rtl/onchip_mem_rr_arb2.sv | 38 +++
 rtl/onchip_mem_arbiter.sv | 111 +++++++++++
 tb/tb_onchip_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_pkg.sv
// Shared types and sizes for the two-requester on-chip RAM arbiter.
// Read-return tags are {valid, port id}. There is no backpressure on returns.
package onchip_mem_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef logic port_id_t;

  typedef struct packed {
    logic     valid;
    port_id_t port;
  } rd_tag_t;
endpackage

// File: rtl/onchip_mem_rr_arb2.sv
// Two-way round-robin grant, combinational in the same cycle as the request.
// Under contention the port opposite the last accepted one wins; no grant while in reset.
module onchip_mem_rr_arb2
  import onchip_mem_pkg::*;
#(
  parameter port_id_t PRIO_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  port_id_t prio;

  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  // After port 0 wins, port 1 gets priority, and the reverse.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= PRIO_INIT;
    end else if (accept) begin
      prio <= grant[0];
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares a single-port RAM between two Avalon-MM requesters using per-cycle round-robin.
// The losing port sees waitrequest. Reads return registered two cycles after the request, in accept order.
module onchip_mem_arbiter
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int PRIO_INIT = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  logic [1:0] req;
  logic [1:0] grant;
  logic       accept;
  logic       rd_accept;
  rd_tag_t    tag_ram;
  rd_tag_t    tag_ret;

  assign req    = {m1_read | m1_write, m0_read | m0_write};
  assign accept = |grant;

  onchip_mem_rr_arb2 #(
    .PRIO_INIT (port_id_t'(PRIO_INIT))
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .accept (accept),
    .grant  (grant)
  );

  assign m0_waitrequest = req[0] & ~grant[0];
  assign m1_waitrequest = req[1] & ~grant[1];
  assign ram_chipselect = accept;
  assign ram_clken      = 1'b1;

  // A read issued together with a write is dropped, so the write alone goes to the RAM.
  always_comb begin
    ram_address    = '0;
    ram_byteenable = '0;
    ram_write      = 1'b0;
    ram_writedata  = '0;
    rd_accept      = 1'b0;
    if (grant[0]) begin
      ram_address    = m0_address;
      ram_byteenable = m0_byteenable;
      ram_write      = m0_write;
      ram_writedata  = m0_writedata;
      rd_accept      = m0_read & ~m0_write;
    end else if (grant[1]) begin
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_write      = m1_write;
      ram_writedata  = m1_writedata;
      rd_accept      = m1_read & ~m1_write;
    end
  end

  // tag_ram tracks the read whose data the RAM presents this cycle; tag_ret is the return strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_ram     <= '0;
      tag_ret     <= '0;
      m0_readdata <= '0;
      m1_readdata <= '0;
    end else begin
      tag_ram <= '{valid: rd_accept, port: grant[1]};
      tag_ret <= tag_ram;
      if (tag_ram.valid) begin
        if (tag_ram.port) m1_readdata <= ram_readdata;
        else              m0_readdata <= ram_readdata;
      end
    end
  end

  assign m0_readdatavalid = tag_ret.valid & ~tag_ret.port;
  assign m1_readdatavalid = tag_ret.valid &  tag_ret.port;

  always @(posedge clk) begin
    if (!reset) begin
      assert (!(m0_read && m0_write) && !(m1_read && m1_write))
        else $warning("onchip_mem_arbiter: read and write asserted together, read dropped");
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter with a behavioural RAM and a queue-based reference model.
module tb_onchip_mem_arbiter;
  localparam int PRIO = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  m0_address, m1_address;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [9:0]  ram_address;
  logic [3:0]  ram_byteenable;
  logic        ram_chipselect, ram_write, ram_clken;
  logic [31:0] ram_writedata, ram_readdata;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .PRIO_INIT(PRIO)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata)
  );

  function automatic logic [31:0] init_val(int i);
    if (i == 5)     return 32'hDEADBEEF;
    if (i == 'h3FF) return 32'h0000_0000;
    return 32'hA000_0000 | i;
  endfunction

  // Bench RAM: registered address, data visible the cycle after the access edge.
  logic [31:0] ram_mem [1024];
  bit          ram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 1024; i++) ram_mem[i] <= init_val(i);
      ram_loaded <= 1'b1;
    end else if (ram_chipselect && ram_clken) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_readdata <= ram_mem[ram_address];
      end
    end
  end

  // Reference model state.
  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } ret_t;
  ret_t        ret_q[$];
  logic [31:0] ref_mem [1024];
  int          winner;
  int          cyc = 0;
  logic        exp_rdv [2];
  logic [31:0] exp_rd  [2];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int model_grant();
    logic r0, r1;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    if (reset) return -1;
    if (r0 && r1) return winner;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  // Compare at the falling edge, then advance the model at the rising edge.
  task automatic cycle();
    int g;
    @(negedge clk);
    g = model_grant();
    check("m0_waitrequest", 32'(m0_waitrequest), 32'((m0_read | m0_write) && g != 0));
    check("m1_waitrequest", 32'(m1_waitrequest), 32'((m1_read | m1_write) && g != 1));
    check("ram_chipselect", 32'(ram_chipselect), 32'(g >= 0));
    check("m0_readdatavalid", 32'(m0_readdatavalid), 32'(exp_rdv[0]));
    check("m1_readdatavalid", 32'(m1_readdatavalid), 32'(exp_rdv[1]));
    check("m0_readdata", m0_readdata, exp_rd[0]);
    check("m1_readdata", m1_readdata, exp_rd[1]);
    if (g == 0) check("ram_address", 32'(ram_address), 32'(m0_address));
    if (g == 1) check("ram_address", 32'(ram_address), 32'(m1_address));
    @(posedge clk);
    cyc++;
    g = model_grant();
    exp_rdv[0] = 1'b0;
    exp_rdv[1] = 1'b0;
    if (reset) begin
      ret_q.delete();
      winner = PRIO;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
    end else begin
      while (ret_q.size() > 0 && ret_q[0].due == cyc) begin
        exp_rdv[ret_q[0].port] = 1'b1;
        exp_rd[ret_q[0].port]  = ret_q[0].data;
        void'(ret_q.pop_front());
      end
      if (g >= 0) begin
        logic        wr, rd;
        logic [9:0]  a;
        logic [3:0]  be;
        logic [31:0] wd;
        wr = (g == 0) ? m0_write : m1_write;
        rd = (g == 0) ? m0_read : m1_read;
        a  = (g == 0) ? m0_address : m1_address;
        be = (g == 0) ? m0_byteenable : m1_byteenable;
        wd = (g == 0) ? m0_writedata : m1_writedata;
        winner = 1 - g;
        if (wr) begin
          for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a][8*b +: 8] = wd[8*b +: 8];
        end else if (rd) begin
          ret_q.push_back('{port: g, data: ref_mem[a], due: cyc + 1});
        end
      end
    end
    #1;
  endtask

  task automatic drive(int p, logic rd, logic wr, logic [9:0] a, logic [3:0] be, logic [31:0] wd);
    if (p == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
    end
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
    winner = PRIO;
    exp_rdv[0] = 1'b0; exp_rdv[1] = 1'b0;
    exp_rd[0] = '0;    exp_rd[1] = '0;
    idle();
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    check("reset m0_readdatavalid", 32'(m0_readdatavalid), 32'h0);
    check("reset m0_readdata", m0_readdata, 32'h0);

    // Single read from m0.
    drive(0, 1, 0, 10'h005, 4'hF, '0);
    #1;
    check("t1 m0_waitrequest", 32'(m0_waitrequest), 32'h0);
    cycle();
    idle();
    cycle();
    check("t1 m0_readdatavalid", 32'(m0_readdatavalid), 32'h1);
    check("t1 m0_readdata", m0_readdata, 32'hDEADBEEF);
    check("t1 m1_readdatavalid", 32'(m1_readdatavalid), 32'h0);
    cycle();

    // Continuous write contention alternates starting with the reset winner.
    do_reset();
    drive(0, 0, 1, 10'h010, 4'hF, 32'h11111111);
    drive(1, 0, 1, 10'h020, 4'hF, 32'h22222222);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t2 m0_waitrequest", 32'(m0_waitrequest), 32'(k % 2));
      cycle();
    end
    idle();
    cycle();
    check("t2 mem 0x010", ram_mem[10'h010], 32'h11111111);
    check("t2 mem 0x020", ram_mem[10'h020], 32'h22222222);

    // Partial write then readback.
    drive(1, 0, 1, 10'h3FF, 4'b0101, 32'hA5A5A5A5);
    cycle();
    drive(1, 1, 0, 10'h3FF, 4'hF, '0);
    cycle();
    idle();
    cycle();
    check("t3 m1_readdatavalid", 32'(m1_readdatavalid), 32'h1);
    check("t3 m1_readdata", m1_readdata, 32'h00A500A5);
    cycle();

    // Interleaved streaming reads.
    drive(0, 1, 0, 10'h001, 4'hF, '0);
    cycle();
    idle();
    drive(1, 1, 0, 10'h002, 4'hF, '0);
    cycle();
    check("t4 m0 first return", m0_readdata, 32'hA0000001);
    idle();
    drive(0, 1, 0, 10'h003, 4'hF, '0);
    cycle();
    check("t4 m1 second return", m1_readdata, 32'hA0000002);
    idle();
    cycle();
    check("t4 m0 third return", m0_readdata, 32'hA0000003);
    cycle();

    // Reset right after an accepted read discards it and restores priority.
    drive(1, 1, 0, 10'h007, 4'hF, '0);
    cycle();
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("t5 m1_readdatavalid", 32'(m1_readdatavalid), 32'h0);
    cycle();
    check("t5 m1_readdatavalid later", 32'(m1_readdatavalid), 32'h0);
    drive(0, 1, 0, 10'h008, 4'hF, '0);
    drive(1, 1, 0, 10'h009, 4'hF, '0);
    #1;
    check("t5 m0_waitrequest", 32'(m0_waitrequest), 32'h0);
    check("t5 m1_waitrequest", 32'(m1_waitrequest), 32'h1);
    cycle();
    drive(0, 0, 0, '0, '0, '0);
    cycle();
    idle();
    cycle();
    cycle();

    // Read and write together on one port: write wins, no return.
    drive(0, 1, 1, 10'h040, 4'hF, 32'h12345678);
    cycle();
    idle();
    cycle();
    check("t6 m0_readdatavalid", 32'(m0_readdatavalid), 32'h0);
    cycle();
    check("t6 mem 0x040", ram_mem[10'h040], 32'h12345678);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
